// File: rtl/memory_respond_pkg.sv
// Shared definitions for the memory_respond data-memory responder:
// log2 helper, read-latency legality check and response record widths.
package memory_respond_pkg;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 8;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit latency_legal(input int latency);
        return (latency >= MIN_READ_LATENCY) && (latency <= MAX_READ_LATENCY);
    endfunction

    // Response record payload carried through the pipe: {write, address, data}.
    // The valid bit travels alongside it, outside the payload.
    function automatic int resp_payload_width(input int data_width, input int address_bits);
        return 1 + address_bits + data_width;
    endfunction

endpackage

// File: rtl/memory_respond_pipe.sv
// Valid-qualified delay line of DEPTH stages. Stage 0 loads from the input,
// later stages shift; the output is the last stage. Async active-low clear.
module memory_respond_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q [DEPTH];
    logic [WIDTH-1:0] data_q  [DEPTH];

    // Shift valid and payload one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/memory_respond.sv
// Data-memory responder: word-organised local store with per-lane writes and
// fixed-latency, valid-qualified read responses.
// Optional feature macro: MEMORY_RESPOND_WRITE_ACK_EN -- when defined, every
// write also returns an acknowledge carrying the merged word.
module memory_respond
    import memory_respond_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int INDEX_BITS   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    memory_read,
    input  logic                    memory_write,
    input  logic [DATA_WIDTH/8-1:0] memory_byte_en,
    input  logic [ADDRESS_BITS-1:0] memory_address,
    input  logic [DATA_WIDTH-1:0]   memory_data,
    output logic                    response_valid,
    output logic                    response_write,
    output logic [ADDRESS_BITS-1:0] response_address,
    output logic [DATA_WIDTH-1:0]   response_data,
    output logic                    protocol_error,
    input  logic                    scan
);

    localparam int NUM_LANES      = DATA_WIDTH / 8;
    localparam int LOG2_NUM_BYTES = log2(NUM_LANES);
    localparam int STORE_DEPTH    = 1 << INDEX_BITS;
    localparam int PAYLOAD_W      = resp_payload_width(DATA_WIDTH, ADDRESS_BITS);
    localparam bit LATENCY_OK     = latency_legal(READ_LATENCY);

    if (!LATENCY_OK) begin : g_bad_latency
        $error("memory_respond: READ_LATENCY out of range 1..8");
    end

    logic [DATA_WIDTH-1:0] store_q [STORE_DEPTH];
    logic [INDEX_BITS-1:0] index;
    logic [DATA_WIDTH-1:0] read_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  active_q;
    logic                  req_read;
    logic                  req_write;
    logic                  protocol_error_q;
    logic                  protocol_error_d;
    logic                  stage_valid;
    logic                  stage_write;
    logic [DATA_WIDTH-1:0] stage_word;
    logic [PAYLOAD_W-1:0]  stage_payload;
    logic [PAYLOAD_W-1:0]  out_payload;

    assign index     = memory_address[LOG2_NUM_BYTES +: INDEX_BITS];
    assign read_word = store_q[index];

    // active_q gates requests from the reset net's own data path, so the store
    // (which has no reset) never samples reset directly. The cycle right after
    // release is still treated as part of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    assign req_read  = active_q & memory_read & ~memory_write;
    assign req_write = active_q & memory_write;

    // Word as it will look after this cycle's write; used for the write ack.
    always_comb begin
        merged_word = read_word;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (memory_byte_en[l]) begin
                merged_word[8*l +: 8] = memory_data[8*l +: 8];
            end
        end
    end

    // Per-lane store write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (req_write) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (memory_byte_en[l]) begin
                    store_q[index][8*l +: 8] <= memory_data[8*l +: 8];
                end
            end
        end
    end

`ifdef MEMORY_RESPOND_WRITE_ACK_EN
    assign stage_valid = req_read | req_write;
    assign stage_write = req_write;
    assign stage_word  = req_write ? merged_word : read_word;
`else
    assign stage_valid = req_read;
    assign stage_write = 1'b0;
    assign stage_word  = read_word;
`endif

    // Invalid slots carry zeros so the outputs read 0 whenever valid is low.
    assign stage_payload = stage_valid ? {stage_write, memory_address, stage_word} : '0;

    assign protocol_error_d = protocol_error_q | (active_q & memory_read & memory_write);

    // Sticky flag for a read and write presented in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            protocol_error_q <= 1'b0;
        end else begin
            protocol_error_q <= protocol_error_d;
        end
    end

    memory_respond_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (PAYLOAD_W)
    ) u_pipe (
        .clk_i   (clock),
        .rst_ni  (reset),
        .valid_i (stage_valid),
        .data_i  (stage_payload),
        .valid_o (response_valid),
        .data_o  (out_payload)
    );

    assign response_write   = out_payload[PAYLOAD_W-1];
    assign response_address = out_payload[DATA_WIDTH +: ADDRESS_BITS];
    assign response_data    = out_payload[DATA_WIDTH-1:0];
    assign protocol_error   = protocol_error_q;

    // scan and CORE are debug-only; address bits outside the index alias away.
    logic unused_sink;
    assign unused_sink = ^{scan, memory_address, 32'(CORE)};

endmodule

// File: tb/tb_memory_respond.sv
// Self-checking bench for memory_respond (default parameters). Expected
// responses come from a shadow word model and are queued when stimulus is
// driven; a monitor captures what the DUT returns, and each test task pairs
// the two queues. Build with MEMORY_RESPOND_WRITE_ACK_EN to cover write acks.
module tb_memory_respond;

    localparam int L = 2;

    typedef struct packed {
        logic        wr;
        logic [19:0] addr;
        logic [31:0] data;
        logic [31:0] due;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        memory_read = 1'b0;
    logic        memory_write = 1'b0;
    logic [3:0]  memory_byte_en = '0;
    logic [19:0] memory_address = '0;
    logic [31:0] memory_data = '0;
    logic        response_valid;
    logic        response_write;
    logic [19:0] response_address;
    logic [31:0] response_data;
    logic        protocol_error;
    logic        scan = 1'b0;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int unsigned cyc = 0;
    resp_t       exp_q[$];
    resp_t       obs_q[$];
    logic [31:0] model [256];

    memory_respond #(
        .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .INDEX_BITS(8), .READ_LATENCY(L)
    ) dut (
        .clock(clock), .reset(reset),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_byte_en(memory_byte_en), .memory_address(memory_address),
        .memory_data(memory_data),
        .response_valid(response_valid), .response_write(response_write),
        .response_address(response_address), .response_data(response_data),
        .protocol_error(protocol_error), .scan(scan)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (response_valid === 1'b1)
            obs_q.push_back('{wr: response_write, addr: response_address,
                              data: response_data, due: cyc});
    end

    task automatic idle();
        memory_read = 1'b0; memory_write = 1'b0;
        memory_byte_en = '0; memory_address = '0; memory_data = '0;
    endtask

    // Drive one request for one cycle (called at a negedge) and queue its expectation.
    task automatic drive(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [19:0] a, input logic [31:0] d);
        logic [7:0]  idx;
        logic [31:0] w;
        idx = a[9:2];
        memory_read = rd; memory_write = wr; memory_byte_en = be;
        memory_address = a; memory_data = d;
        if (wr) begin
            w = model[idx];
            for (int l = 0; l < 4; l++) if (be[l]) w[8*l +: 8] = d[8*l +: 8];
            model[idx] = w;
`ifdef MEMORY_RESPOND_WRITE_ACK_EN
            exp_q.push_back('{wr: 1'b1, addr: a, data: w, due: cyc + L});
`endif
        end else if (rd) begin
            exp_q.push_back('{wr: 1'b0, addr: a, data: model[idx], due: cyc + L});
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total_cnt++;
        if ({response_valid, response_write, response_address, response_data, protocol_error} !== '0)
            $display("FAIL reset_held: outputs=%h required 0",
                     {response_valid, response_write, response_address, response_data, protocol_error});
        else pass_cnt++;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            total_cnt++;
            if ({response_valid, response_write, response_address, response_data, protocol_error} !== '0)
                $display("FAIL reset_idle[%0d]: valid=%b err=%b addr=%h data=%h required all 0",
                         i, response_valid, protocol_error, response_address, response_data);
            else pass_cnt++;
        end
        obs_q.delete();
    endtask

    task automatic test_write_read();
        resp_t e, o;
        drive(1'b0, 1'b1, 4'b1111, 20'h00004, 32'hdeadbeef);
        drive(1'b1, 1'b0, 4'b0000, 20'h00004, 32'h0);
        drive(1'b0, 1'b1, 4'b1111, 20'h00010, 32'h01234567);
        drive(1'b1, 1'b0, 4'b1111, 20'h00012, 32'h0);
        idle();
        repeat (L + 3) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total_cnt++;
            if (obs_q.size() == 0) $display("FAIL write_read: missing response, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL write_read: got %h required %h", o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL write_read_extra: %0d extra responses, required 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_byte_en();
        resp_t e, o;
        drive(1'b0, 1'b1, 4'b1111, 20'h00008, 32'hffffffff);
        drive(1'b0, 1'b1, 4'b0010, 20'h00009, 32'h00001200);
        drive(1'b0, 1'b1, 4'b0000, 20'h00008, 32'h55555555);
        drive(1'b1, 1'b0, 4'b0000, 20'h00008, 32'h0);
        drive(1'b0, 1'b1, 4'b1001, 20'h0000b, 32'hab0000cd);
        drive(1'b1, 1'b0, 4'b0001, 20'h0000a, 32'h0);
        idle();
        repeat (L + 3) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total_cnt++;
            if (obs_q.size() == 0) $display("FAIL byte_en: missing response, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL byte_en: got %h required %h", o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL byte_en_extra: %0d extra responses, required 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        resp_t e, o;
        drive(1'b0, 1'b1, 4'b1111, 20'h00000, 32'ha5a5a5a5);
        drive(1'b1, 1'b0, 4'b1111, 20'h00000, 32'h0);
        drive(1'b1, 1'b0, 4'b1111, 20'h00004, 32'h0);
        drive(1'b1, 1'b0, 4'b1111, 20'h00008, 32'h0);
        drive(1'b1, 1'b0, 4'b1111, 20'h00400, 32'h0);
        drive(1'b1, 1'b0, 4'b1111, 20'hff3fc, 32'h0);
        idle();
        repeat (L + 3) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total_cnt++;
            if (obs_q.size() == 0) $display("FAIL back_to_back: missing response, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL back_to_back: got %h required %h", o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL back_to_back_extra: %0d extra, required 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_protocol_error();
        resp_t e, o;
        total_cnt++;
        if (protocol_error !== 1'b0) $display("FAIL perr_before: got %b required 0", protocol_error);
        else pass_cnt++;
        drive(1'b1, 1'b1, 4'b1111, 20'h0000c, 32'h0badf00d);
        idle();
        @(negedge clock);
        total_cnt++;
        if (protocol_error !== 1'b1) $display("FAIL perr_set: got %b required 1", protocol_error);
        else pass_cnt++;
        drive(1'b1, 1'b0, 4'b0000, 20'h0000c, 32'h0);
        idle();
        repeat (L + 3) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total_cnt++;
            if (obs_q.size() == 0) $display("FAIL perr_rw: missing response, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL perr_rw: got %h required %h", o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL perr_rw_extra: %0d extra, required 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
        total_cnt++;
        if (protocol_error !== 1'b1) $display("FAIL perr_sticky: got %b required 1", protocol_error);
        else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
        resp_t e, o;
        memory_read = 1'b1; memory_address = 20'h00004; memory_byte_en = 4'b1111;
        @(negedge clock);
        memory_address = 20'h00008;
        @(posedge clock);
        #1;
        idle();
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({response_valid, response_address, response_data, protocol_error} !== '0)
            $display("FAIL reset_async: valid=%b addr=%h data=%h err=%b required all 0",
                     response_valid, response_address, response_data, protocol_error);
        else pass_cnt++;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (L + 4) @(negedge clock);
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL reset_drop: %0d responses, required 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
        total_cnt++;
        if (protocol_error !== 1'b0) $display("FAIL reset_perr_clear: got %b required 0", protocol_error);
        else pass_cnt++;
        drive(1'b1, 1'b0, 4'b1111, 20'h00004, 32'h0);
        idle();
        repeat (L + 3) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total_cnt++;
            if (obs_q.size() == 0) $display("FAIL store_retained: missing response, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL store_retained: got %h required %h", o, e);
                else pass_cnt++;
            end
        end
        obs_q.delete();
    endtask

`ifdef MEMORY_RESPOND_WRITE_ACK_EN
    task automatic test_write_ack();
        resp_t e, o;
        drive(1'b0, 1'b1, 4'b1111, 20'h00020, 32'hffffffff);
        drive(1'b0, 1'b1, 4'b0011, 20'h00020, 32'h12345678);
        idle();
        repeat (L + 3) @(negedge clock);
        total_cnt++;
        if (exp_q.size() != 2 || exp_q[1].data !== 32'hffff5678 || exp_q[1].wr !== 1'b1)
            $display("FAIL ack_model: queued %0d entries, required 2 with data ffff5678", exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total_cnt++;
            if (obs_q.size() == 0) $display("FAIL write_ack: missing ack, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL write_ack: got %h required %h", o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL write_ack_extra: %0d extra, required 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_en();
        test_back_to_back();
        test_protocol_error();
        test_reset_inflight();
`ifdef MEMORY_RESPOND_WRITE_ACK_EN
        test_write_ack();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
